// File: rtl/feedback_delay_cal_if.sv
// Control/status and delay-chain signals of the feedback delay calibration block.
// The slave side is the controller; the master side is the config registers plus chain.
interface feedback_delay_cal_if #(
    parameter int TAP_W = 4,
    parameter int CNT_W = 12
);
    logic             start;
    logic [CNT_W-1:0] target;
    logic [CNT_W-1:0] tol;
    logic             ro_in;
    logic             ro_en;
    logic [TAP_W-1:0] tap_sel;
    logic             busy;
    logic             done;
    logic             locked;
    logic             fail;
    logic [CNT_W-1:0] count_out;

    modport master (
        output start, target, tol, ro_in,
        input  ro_en, tap_sel, busy, done, locked, fail, count_out
    );

    modport slave (
        input  start, target, tol, ro_in,
        output ro_en, tap_sel, busy, done, locked, fail, count_out
    );
endinterface

// File: rtl/feedback_delay_cal.sv
// Closed-loop tap calibration for the feedback inverter-chain ring oscillator.
// Define FBCAL_TRACK_EN to keep re-measuring and tracking after a lock.
module feedback_delay_cal #(
    parameter int TAP_W         = 4,
    parameter int TAP_INIT      = 8,
    parameter int CNT_W         = 12,
    parameter int WIN_CYCLES    = 256,
    parameter int SETTLE_CYCLES = 8,
    parameter int MAX_ITER      = 32
) (
    input logic                  clk,
    input logic                  rstn,
    feedback_delay_cal_if.slave  bus
);
    localparam int CYC_MAX = (WIN_CYCLES > SETTLE_CYCLES) ? WIN_CYCLES : SETTLE_CYCLES;
    localparam int CYC_W   = $clog2(CYC_MAX + 1);
    localparam int ITER_W  = $clog2(MAX_ITER + 1);
    localparam logic [TAP_W-1:0] TAP_MAX = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_MEASURE,
        S_COMPARE,
        S_LOCK,
`ifdef FBCAL_TRACK_EN
        S_FAIL,
        S_TRACK
`else
        S_FAIL
`endif
    } state_t;

    state_t           state, state_n;
    logic [CYC_W-1:0] cyc;
    logic [CNT_W-1:0] edge_cnt;
    logic [ITER_W-1:0] iter;
    logic [ITER_W-1:0] iter_nxt;
    logic [TAP_W-1:0] tap_q;
    logic [CNT_W-1:0] tgt_q, tol_q, count_q;
    logic             locked_q, fail_q;
    logic             s1, s2, s3;
    logic             ro_edge;
    logic [CNT_W:0]   win_hi, win_lo, cnt_wide;
    logic             too_fast, too_slow;
    logic             load, tap_inc, tap_dec, set_lock, set_fail;
    logic             track_active;

`ifdef FBCAL_TRACK_EN
    logic track_q;
    assign track_active = track_q;
`else
    assign track_active = 1'b0;
`endif

    assign ro_edge  = s2 & ~s3;
    assign iter_nxt = iter + 1'b1;

    // Tolerance window is evaluated one bit wider so target+tol cannot wrap.
    assign cnt_wide = {1'b0, edge_cnt};
    assign win_hi   = {1'b0, tgt_q} + {1'b0, tol_q};
    assign win_lo   = (tgt_q > tol_q) ? {1'b0, tgt_q - tol_q} : '0;
    assign too_fast = cnt_wide > win_hi;
    assign too_slow = cnt_wide < win_lo;

    always_comb begin
        state_n  = state;
        load     = 1'b0;
        tap_inc  = 1'b0;
        tap_dec  = 1'b0;
        set_lock = 1'b0;
        set_fail = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    state_n = S_SETTLE;
                    load    = 1'b1;
                end
            end
            S_SETTLE:  if (cyc == CYC_W'(SETTLE_CYCLES - 1)) state_n = S_MEASURE;
            S_MEASURE: if (cyc == CYC_W'(WIN_CYCLES - 1))    state_n = S_COMPARE;
            S_COMPARE: begin
                if (track_active && !bus.start) begin
                    state_n = S_IDLE;
                end else if (too_fast || too_slow) begin
                    // Too many edges means the chain is too fast: add delay.
                    if ((too_fast && tap_q == TAP_MAX) || (too_slow && tap_q == '0) ||
                        (!track_active && iter_nxt == ITER_W'(MAX_ITER))) begin
                        state_n  = S_FAIL;
                        set_fail = 1'b1;
                    end else begin
                        state_n = S_SETTLE;
                        tap_inc = too_fast;
                        tap_dec = too_slow;
                    end
                end else if (track_active) begin
                    state_n = S_SETTLE;
                end else begin
                    state_n  = S_LOCK;
                    set_lock = 1'b1;
                end
            end
`ifdef FBCAL_TRACK_EN
            S_LOCK:  state_n = S_TRACK;
            S_TRACK: state_n = S_SETTLE;
`else
            S_LOCK:  state_n = S_IDLE;
`endif
            S_FAIL:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= S_IDLE;
            cyc      <= '0;
            edge_cnt <= '0;
            iter     <= '0;
            tap_q    <= TAP_W'(TAP_INIT);
            tgt_q    <= '0;
            tol_q    <= '0;
            count_q  <= '0;
            locked_q <= 1'b0;
            fail_q   <= 1'b0;
            s1       <= 1'b0;
            s2       <= 1'b0;
            s3       <= 1'b0;
`ifdef FBCAL_TRACK_EN
            track_q  <= 1'b0;
`endif
        end else begin
            state <= state_n;
            s1    <= bus.ro_in;
            s2    <= s1;
            s3    <= s2;

            if (state_n != state || state == S_IDLE) cyc <= '0;
            else                                     cyc <= cyc + 1'b1;

            if (state == S_SETTLE && state_n == S_MEASURE)
                edge_cnt <= '0;
            else if (state == S_MEASURE && ro_edge && edge_cnt != '1)
                edge_cnt <= edge_cnt + 1'b1;

            if (load) begin
                tgt_q    <= bus.target;
                tol_q    <= bus.tol;
                tap_q    <= TAP_W'(TAP_INIT);
                iter     <= '0;
                locked_q <= 1'b0;
                fail_q   <= 1'b0;
`ifdef FBCAL_TRACK_EN
                track_q  <= 1'b0;
`endif
            end

            if (state == S_COMPARE) begin
                count_q <= edge_cnt;
                if (!track_active) iter <= iter_nxt;
            end

            if (tap_inc) tap_q <= tap_q + 1'b1;
            if (tap_dec) tap_q <= tap_q - 1'b1;
            if (set_lock) locked_q <= 1'b1;
            if (set_fail) begin
                fail_q   <= 1'b1;
                locked_q <= 1'b0;
            end
`ifdef FBCAL_TRACK_EN
            if (state == S_TRACK) track_q <= 1'b1;
`endif
        end
    end

    always_comb begin
        bus.ro_en     = (state == S_SETTLE) || (state == S_MEASURE) || (state == S_COMPARE);
        bus.busy      = (state != S_IDLE) && (state != S_LOCK) && (state != S_FAIL);
`ifdef FBCAL_TRACK_EN
        if (state == S_TRACK) begin
            bus.ro_en = 1'b1;
        end
`endif
        bus.done      = (state == S_LOCK) || (state == S_FAIL);
        bus.tap_sel   = tap_q;
        bus.locked    = locked_q;
        bus.fail      = fail_q;
        bus.count_out = count_q;
    end
endmodule

// File: tb/tb_feedback_delay_cal.sv
// Scoreboard bench for feedback_delay_cal: a behavioural ring oscillator whose
// half period is (tap_sel+1) clk cycles, directed calibration runs, and reset checks.
module tb_feedback_delay_cal;
    localparam int TAP_W = 4;
    localparam int CNT_W = 12;
    localparam int ITER  = 8 + 256 + 1;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    feedback_delay_cal_if #(.TAP_W(TAP_W), .CNT_W(CNT_W)) bus();

    feedback_delay_cal #(
        .TAP_W(TAP_W), .TAP_INIT(8), .CNT_W(CNT_W),
        .WIN_CYCLES(256), .SETTLE_CYCLES(8), .MAX_ITER(32)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .bus(bus)
    );

    typedef struct {
        string name;
        int    locked;
        int    fail;
        int    tap;
        int    cnt_lo;
        int    cnt_hi;
        int    latency;
        int    issue;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0d expected=%0d", name, got, exp);
        end
    endtask

    task automatic checkRange(input string name, input int got, input int lo, input int hi);
        total++;
        if (got < lo || got > hi) begin
            bad++;
            $display("[TB] FAIL %s got=%0d expected=[%0d,%0d]", name, got, lo, hi);
        end
    endtask

    // Chain model: oscillates only while the loop is closed.
    int ph;
    initial begin
        bus.ro_in = 1'b0;
        ph = 0;
        forever begin
            @(posedge clk);
            #3;
            if (!bus.ro_en) begin
                bus.ro_in = 1'b0;
                ph = 0;
            end else begin
                ph++;
                if (ph >= int'(bus.tap_sel) + 1) begin
                    bus.ro_in = ~bus.ro_in;
                    ph = 0;
                end
            end
        end
    end

    exp_t e;
    always @(negedge clk) begin
        if (bus.done) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_done got=1 expected=0 at cycle %0d", cyc);
            end else begin
                e = exp_q.pop_front();
                checkOutput({e.name, "_locked"}, int'(bus.locked), e.locked);
                checkOutput({e.name, "_fail"}, int'(bus.fail), e.fail);
                checkOutput({e.name, "_tap"}, int'(bus.tap_sel), e.tap);
                checkRange({e.name, "_count"}, int'(bus.count_out), e.cnt_lo, e.cnt_hi);
                checkOutput({e.name, "_latency"}, cyc - e.issue, e.latency);
                checkOutput({e.name, "_busy_at_done"}, int'(bus.busy), 0);
            end
        end
    end

    task automatic applyStimulus(input string name, input int tgt, input int tl,
                                 input int xlocked, input int xfail, input int xtap,
                                 input int lo, input int hi, input int iters);
        exp_t x;
        x.name    = name;
        x.locked  = xlocked;
        x.fail    = xfail;
        x.tap     = xtap;
        x.cnt_lo  = lo;
        x.cnt_hi  = hi;
        x.latency = iters * ITER + 1;
        x.issue   = cyc;
        exp_q.push_back(x);
        checkOutput({name, "_busy_before"}, int'(bus.busy), 0);
        bus.target = CNT_W'(tgt);
        bus.tol    = CNT_W'(tl);
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start  = 1'b0;
        checkOutput({name, "_busy_rise"}, int'(bus.busy), 1);
        checkOutput({name, "_locked_cleared"}, int'(bus.locked), 0);
        checkOutput({name, "_tap_init"}, int'(bus.tap_sel), 8);
    endtask

    task automatic waitDone(input string name, input int limit);
        int n = 0;
        while (exp_q.size() != 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("[TB] FAIL %s_timeout got=%0d expected<%0d cycles", name, n, limit);
            exp_q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        rstn       = 1'b0;
        bus.start  = 1'b1;
        bus.target = '0;
        bus.tol    = '0;
        repeat (2) @(negedge clk);
        checkOutput("rst_ro_en", int'(bus.ro_en), 0);
        checkOutput("rst_tap", int'(bus.tap_sel), 8);
        checkOutput("rst_busy", int'(bus.busy), 0);
        checkOutput("rst_done", int'(bus.done), 0);
        checkOutput("rst_locked", int'(bus.locked), 0);
        checkOutput("rst_fail", int'(bus.fail), 0);
        checkOutput("rst_count", int'(bus.count_out), 0);
        bus.start = 1'b0;
        rstn      = 1'b1;
        repeat (2) @(negedge clk);

        // Tap 8 gives period 18: 14 or 15 edges per 256-cycle window.
        applyStimulus("lock", 15, 1, 1, 0, 8, 14, 15, 1);
        waitDone("lock", 2 * ITER);
        checkOutput("lock_sticky", int'(bus.locked), 1);
        checkOutput("lock_ro_en_idle", int'(bus.ro_en), 0);

        // 8 (14/15) -> 9 (12/13) locks in [11,13].
        applyStimulus("up", 12, 1, 1, 0, 9, 12, 13, 2);
        waitDone("up", 3 * ITER);

        // 8 -> 7 (16) -> 6 (18/19) locks in [18,20]; mid-run target change and start are ignored.
        applyStimulus("down", 19, 1, 1, 0, 6, 18, 19, 3);
        repeat (100) @(negedge clk);
        bus.target = 12'd4000;
        bus.tol    = 12'd0;
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start  = 1'b0;
        waitDone("down", 4 * ITER);

        // Unreachable count: walks down to tap 0 (period 2, 128 edges), 9 compares.
        applyStimulus("floor", 4000, 0, 0, 1, 0, 128, 128, 9);
        waitDone("floor", 10 * ITER);
        checkOutput("floor_tap_hold", int'(bus.tap_sel), 0);

        // Zero target: walks up to tap 15 (period 32, 8 edges), 8 compares.
        applyStimulus("ceil", 0, 0, 0, 1, 15, 8, 8, 8);
        waitDone("ceil", 9 * ITER);

        // Abort during the second window (tap 7) with a synchronous reset.
        bus.target = 12'd19;
        bus.tol    = 12'd1;
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start  = 1'b0;
        repeat (ITER + 8 + 100) @(negedge clk);
        checkOutput("abort_tap_before", int'(bus.tap_sel), 7);
        rstn = 1'b0;
        @(negedge clk);
        checkOutput("abort_ro_en", int'(bus.ro_en), 0);
        checkOutput("abort_tap", int'(bus.tap_sel), 8);
        checkOutput("abort_busy", int'(bus.busy), 0);
        checkOutput("abort_fail", int'(bus.fail), 0);
        checkOutput("abort_count", int'(bus.count_out), 0);
        checkOutput("abort_done", int'(bus.done), 0);
        rstn = 1'b1;
        repeat (3 * ITER) @(negedge clk);
        checkOutput("abort_still_idle", int'(bus.busy), 0);

        applyStimulus("relock", 15, 1, 1, 0, 8, 14, 15, 1);
        waitDone("relock", 2 * ITER);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
